m_gt_qpll_rst_ctrl: RTL and testbench

- Initiator side of the QPLL reset/lock handshake: drives the QPLL reset request and monitors the lock indication.
- Generates a reset pulse of fixed length, then waits for lock with a timeout, and qualifies lock as stable.
- Re-issues the reset on timeout or lock loss; reports ready, fail and retry status to the timing-setup logic.
- Sits between system control (sysclk domain) and the GTHE4 common QPLL1 wrapper.

---
 rtl/m_gt_pkg.sv | 34 +++
 rtl/m_sync_2ff.sv | 28 ++
 rtl/m_gt_qpll_rst_ctrl.sv | 147 ++++++++++++++
 tb/tb_m_gt_qpll_rst_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/m_gt_pkg.sv
// Shared types and helpers for the GT common reset/lock control blocks.
// Holds the QPLL sequencer state encoding and the retry counter helpers.
package m_gt_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAIL      = 3'd4
    } qpll_state_e;

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + RETRY_W'(1);
    endfunction

    // True when the attempt now failing uses up the retry budget.
    function automatic logic retry_exhausted(input logic [RETRY_W-1:0] v,
                                             input int unsigned max_retry);
        return (int'(unsigned'(v)) + 1) >= int'(max_retry);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/m_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous status bits entering a clock domain.
// Asynchronous active-high reset loads both flops with RST_VAL.
module m_sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m_gt_qpll_rst_ctrl.sv
// QPLL1 reset/lock sequencer: pulses the QPLL reset, waits for lock with a
// timeout, qualifies lock as stable and retries on timeout or lock loss.
module m_gt_qpll_rst_ctrl
    import m_gt_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 256,
    parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 4
) (
    input  logic               sysclk_i,
    input  logic               reset_i,
    input  logic               restart_i,
    input  logic               qpll_lock_i,
    output logic               qpll_reset_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam int unsigned CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);

    logic lock_s;

    m_sync_2ff #(
        .WIDTH  (1),
        .RST_VAL(1'b0)
    ) u_lock_sync (
        .clk_i(sysclk_i),
        .rst_i(reset_i),
        .d_i  (qpll_lock_i),
        .q_o  (lock_s)
    );

    qpll_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               qpll_reset_q, qpll_reset_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    qpll_state_e        after_fail_st;
    logic [RETRY_W-1:0] retry_inc;

    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            qpll_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            qpll_reset_q <= qpll_reset_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    // A timeout and a lock loss in READY are both failed attempts.
    always_comb begin
        retry_inc     = retry_sat_inc(retry_q);
        after_fail_st = retry_exhausted(retry_q, MAX_RETRY) ? ST_FAIL : ST_RST;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        if (restart_i) begin
            state_d = ST_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = after_fail_st;
                        cnt_d   = '0;
                        retry_d = retry_inc;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (!lock_s) begin
                        state_d = after_fail_st;
                        cnt_d   = '0;
                        retry_d = retry_inc;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        qpll_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
        ready_d      = (state_d == ST_READY);
        fail_d       = (state_d == ST_FAIL);
    end

    assign qpll_reset_o = qpll_reset_q;
    assign ready_o      = ready_q;
    assign fail_o       = fail_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_m_gt_qpll_rst_ctrl.sv
// Directed bench for the QPLL reset/lock sequencer: vector table plus
// hand-written multi-cycle sequences (glitch, timeout/fail, restart, async reset).
module tb_m_gt_qpll_rst_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       restart_i;
    logic       qpll_lock_i;
    logic       qpll_reset_o;
    logic       ready_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_gt_qpll_rst_ctrl #(
        .RST_PULSE_CYC   (8),
        .LOCK_TIMEOUT_CYC(100),
        .LOCK_STABLE_CYC (16),
        .MAX_RETRY       (3)
    ) dut (
        .sysclk_i    (clk),
        .reset_i     (reset_i),
        .restart_i   (restart_i),
        .qpll_lock_i (qpll_lock_i),
        .qpll_reset_o(qpll_reset_o),
        .ready_o     (ready_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o)
    );

    typedef struct {
        logic        lock;
        int          ncyc;
        logic        e_rst;
        logic        e_rdy;
        logic        e_fail;
        logic [3:0]  e_retry;
    } vec_t;

    vec_t vecs[11];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic e_rst, input logic e_rdy,
                       input logic e_fail, input logic [3:0] e_retry);
        checks++;
        if (qpll_reset_o !== e_rst || ready_o !== e_rdy || fail_o !== e_fail ||
            retry_cnt_o !== e_retry) begin
            errors++;
            $display("FAIL %s: got rst=%0b rdy=%0b fail=%0b retry=%0d, want rst=%0b rdy=%0b fail=%0b retry=%0d",
                     nm, qpll_reset_o, ready_o, fail_o, retry_cnt_o, e_rst, e_rdy, e_fail, e_retry);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenario 1 (normal lock) then scenario 5 (lock loss in READY, relock).
        vecs[0]  = '{1'b0,  7, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0,  1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 20, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 18, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1,  1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{1'b0,  2, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[6]  = '{1'b0,  1, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b0,  7, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[8]  = '{1'b0,  1, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{1'b1, 18, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[10] = '{1'b1,  1, 1'b0, 1'b1, 1'b0, 4'd0};

        reset_i     = 1'b1;
        restart_i   = 1'b0;
        qpll_lock_i = 1'b0;
        #2;
        chk("reset_state", 1'b1, 1'b0, 1'b0, 4'd0);
        tick(3);
        chk("reset_held", 1'b1, 1'b0, 1'b0, 4'd0);
        reset_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            qpll_lock_i = vecs[i].lock;
            tick(vecs[i].ncyc);
            chk($sformatf("vec%0d", i), vecs[i].e_rst, vecs[i].e_rdy, vecs[i].e_fail, vecs[i].e_retry);
        end

        // Scenario 6: async reset between edges while waiting for lock.
        qpll_lock_i = 1'b0;
        tick(3);
        chk("loss_to_rst", 1'b1, 1'b0, 1'b0, 4'd1);
        tick(8);
        chk("wait_lock_pre_areset", 1'b0, 1'b0, 1'b0, 4'd1);
        #3;
        reset_i = 1'b1;
        #1;
        chk("async_reset_now", 1'b1, 1'b0, 1'b0, 4'd0);
        tick(2);
        reset_i = 1'b0;

        // Scenario 2: lock high 10 cycles, drops 1 cycle, then stays high.
        tick(8);
        chk("glitch_wait_lock", 1'b0, 1'b0, 1'b0, 4'd0);
        qpll_lock_i = 1'b1;
        tick(10);
        qpll_lock_i = 1'b0;
        tick(1);
        qpll_lock_i = 1'b1;
        tick(8);
        chk("glitch_no_early_ready", 1'b0, 1'b0, 1'b0, 4'd0);
        tick(10);
        chk("glitch_ready_minus1", 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("glitch_ready", 1'b0, 1'b1, 1'b0, 4'd0);

        // Restart from READY coinciding with lock loss: restart wins.
        restart_i   = 1'b1;
        qpll_lock_i = 1'b0;
        tick(1);
        restart_i = 1'b0;
        chk("restart_from_ready", 1'b1, 1'b0, 1'b0, 4'd0);

        // Scenario 3: three timed-out attempts, then FAIL.
        for (int k = 1; k <= 3; k++) begin
            tick(7);
            chk($sformatf("to%0d_pulse_hi", k), 1'b1, 1'b0, 1'b0, 4'(k - 1));
            tick(1);
            chk($sformatf("to%0d_pulse_lo", k), 1'b0, 1'b0, 1'b0, 4'(k - 1));
            tick(99);
            chk($sformatf("to%0d_pre_timeout", k), 1'b0, 1'b0, 1'b0, 4'(k - 1));
            tick(1);
            chk($sformatf("to%0d_timeout", k), 1'b1, 1'b0, (k == 3), 4'(k));
        end
        tick(20);
        chk("fail_held", 1'b1, 1'b0, 1'b1, 4'd3);

        // Scenario 4: restart from FAIL then lock.
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        chk("restart_from_fail", 1'b1, 1'b0, 1'b0, 4'd0);
        tick(7);
        chk("restart_pulse_hi", 1'b1, 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("restart_pulse_lo", 1'b0, 1'b0, 1'b0, 4'd0);
        qpll_lock_i = 1'b1;
        tick(18);
        chk("restart_ready_minus1", 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("restart_ready", 1'b0, 1'b1, 1'b0, 4'd0);

        // Restart during the reset pulse restarts the pulse length.
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        tick(4);
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        tick(7);
        chk("rst_restart_pulse_hi", 1'b1, 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("rst_restart_pulse_lo", 1'b0, 1'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
